// File: rtl/cpu_write_buffer.sv
// Posted-write buffer: captures CPU writes into a FIFO, then drains each entry to the cache and then to SDRAM, in order.
// Latency: cpu_ack 1 edge after cpu_req; cache_req 1 edge after the push; pop on the edge that samples sdram_ack.
// Backpressure: while full, cpu_ack is withheld and the request waits; the drain blocks on cache_wr_ack and on sdram_ack.
//
// Ports:
//   clk, reset (async, active low)
//   cpu_*          : CPU write port (req held until ack; strobes active low)
//   cache_*        : head entry offered to the cache, req/ack (ack held until req drops)
//   sdram_*        : head entry issued to SDRAM, req/ack (ack is a one-cycle pulse)
//   empty, full    : FIFO/drain status for the read arbiter
module cpu_write_buffer #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_req,
    input  logic        cpu_rwl,
    input  logic        cpu_rwu,
    input  logic [15:0] data_from_cpu,
    output logic        cpu_ack,
    output logic [31:0] cache_addr,
    output logic [15:0] cache_data,
    output logic        cache_rwl,
    output logic        cache_rwu,
    output logic        cache_req,
    input  logic        cache_wr_ack,
    output logic [31:0] sdram_addr,
    output logic [15:0] sdram_data,
    output logic        sdram_rwl,
    output logic        sdram_rwu,
    output logic        sdram_req,
    input  logic        sdram_ack,
    output logic        empty,
    output logic        full
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    // Entry layout: {addr[31:1], rwu, rwl, data}
    localparam int ENTRY_W = 31 + 1 + 1 + 16;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CACHE_WR = 2'd1;
    localparam logic [1:0] ST_SDRAM_WR = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    logic [ENTRY_W-1:0]    r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [1:0]            r_state;
    logic                  r_cpu_ack;
    logic                  r_cache_req;
    logic                  r_sdram_req;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic [ENTRY_W-1:0]    w_head;
    logic [31:0]           w_head_addr;
    // Address bit 0 is a byte lane selector on the CPU side and is not stored.
    logic                  w_unused_addr0;

    assign w_unused_addr0 = cpu_addr[0];

    assign w_full = (r_count == FULL_CNT);
    // Only a fresh request (ack not yet given) may push, so a held request enqueues once.
    assign w_push = cpu_req && !r_cpu_ack && !w_full;
    assign w_pop  = (r_state == ST_SDRAM_WR) && sdram_ack;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cpu_addr[31:1], cpu_rwu, cpu_rwl, data_from_cpu};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_cpu_ack <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Ack follows the request down; it rises only on an actual push.
            r_cpu_ack <= cpu_req && (r_cpu_ack || !w_full);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cache_req <= 1'b0;
            r_sdram_req <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_count != '0) begin
                        r_cache_req <= 1'b1;
                        r_state     <= ST_CACHE_WR;
                    end
                end
                ST_CACHE_WR: begin
                    if (cache_wr_ack) begin
                        r_cache_req <= 1'b0;
                        r_sdram_req <= 1'b1;
                        r_state     <= ST_SDRAM_WR;
                    end
                end
                ST_SDRAM_WR: begin
                    if (sdram_ack) begin
                        r_sdram_req <= 1'b0;
                        r_state     <= ST_RELEASE;
                    end
                end
                default: begin
                    // The cache may still be holding its ack from this entry;
                    // a new request must not overlap it.
                    if (!cache_wr_ack) begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_addr = {w_head[ENTRY_W-1:18], 1'b0};

    assign cache_addr = w_head_addr;
    assign cache_data = w_head[15:0];
    assign cache_rwl  = w_head[16];
    assign cache_rwu  = w_head[17];
    assign sdram_addr = w_head_addr;
    assign sdram_data = w_head[15:0];
    assign sdram_rwl  = w_head[16];
    assign sdram_rwu  = w_head[17];

    assign cpu_ack   = r_cpu_ack;
    assign cache_req = r_cache_req;
    assign sdram_req = r_sdram_req;
    assign full      = w_full;
    assign empty     = (r_count == '0) && (r_state == ST_IDLE);

endmodule
